// File: rtl/buzzer_seq_ctrl.sv
// APB note sequencer: FIFO of (half-period, duration) words played as square-wave tones on buzzerOut.
// Optional macro BUZZER_SEQ_IRQ_EN adds the sequence-done interrupt (buzzerIrq, IRQEN, STATUS.DONE).
module buzzer_seq_ctrl #(
  parameter int ADDRWIDTH  = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 50000
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
`ifdef BUZZER_SEQ_IRQ_EN
  output logic                 buzzerIrq,
`endif
  output logic                 buzzerOut
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [ADDRWIDTH-3:0] A_CTRL   = 'd0;
  localparam logic [ADDRWIDTH-3:0] A_STATUS = 'd1;
  localparam logic [ADDRWIDTH-3:0] A_NOTE   = 'd2;
  localparam logic [ADDRWIDTH-3:0] A_GAP    = 'd3;
  localparam logic [ADDRWIDTH-3:0] A_IRQEN  = 'd4;

  logic [ADDRWIDTH-3:0] reg_addr;
  logic                 wr_en, wr_ctrl, wr_status, push, flush, pop, push_ok;
  logic                 en, ovf, empty, full, busy, kill, tick_wrap, last_tick, fin;
  logic [15:0]          gap_r, half_r, tone_cnt, dur_cnt;
  logic [PW-1:0]        presc;
  logic [1:0]           state;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [31:0]          head;
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic                 done;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, PADDR[1:0]};
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;

  assign reg_addr  = PADDR[ADDRWIDTH-1:2];
  assign wr_en     = PSEL & PWRITE & ~PENABLE;
  assign wr_ctrl   = wr_en & (reg_addr == A_CTRL);
  assign wr_status = wr_en & (reg_addr == A_STATUS);
  assign push      = wr_en & (reg_addr == A_NOTE);
  assign flush     = wr_ctrl & PWDATA[1];

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign head    = mem[rptr];
  assign pop     = (state == S_LOAD) & ~empty;
  assign push_ok = push & ~full & ~flush;
  assign busy    = (state != S_IDLE);

  // FIFO storage carries no reset; only pointers and count define its contents
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wptr] <= PWDATA;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en    <= 1'b0;
      gap_r <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_ctrl) en <= PWDATA[0];
      if (wr_en && reg_addr == A_GAP) gap_r <= PWDATA[15:0];
      if (push && full && !flush)     ovf <= 1'b1;
      else if (wr_status && PWDATA[3]) ovf <= 1'b0;
    end
  end

  // Clearing EN aborts on the very write that clears it
  assign kill      = ~en | (wr_ctrl & ~PWDATA[0]);
  assign tick_wrap = (presc == PW'(TICK_DIV - 1));
  assign last_tick = tick_wrap & (dur_cnt == 16'd1);
  assign fin       = ~kill & last_tick &
                     (((state == S_PLAY) & (gap_r == '0)) | (state == S_GAP));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_IDLE;
      buzzerOut <= 1'b0;
      half_r    <= '0;
      tone_cnt  <= '0;
      dur_cnt   <= '0;
      presc     <= '0;
    end else if (kill) begin
      state     <= S_IDLE;
      buzzerOut <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          buzzerOut <= 1'b0;
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          half_r    <= head[15:0];
          dur_cnt   <= head[31:16];
          tone_cnt  <= '0;
          presc     <= '0;
          buzzerOut <= 1'b0;
          state     <= (empty || head[31:16] == '0) ? S_IDLE : S_PLAY;
        end
        S_PLAY: begin
          if (half_r != '0) begin
            if (tone_cnt == half_r - 16'd1) begin
              tone_cnt  <= '0;
              buzzerOut <= ~buzzerOut;
            end else begin
              tone_cnt <= tone_cnt + 16'd1;
            end
          end
          if (tick_wrap) begin
            presc <= '0;
            if (last_tick) begin
              // GAP length latched here so later GAP writes only hit later gaps
              buzzerOut <= 1'b0;
              dur_cnt   <= gap_r;
              state     <= (gap_r != '0) ? S_GAP : S_IDLE;
            end else begin
              dur_cnt <= dur_cnt - 16'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          buzzerOut <= 1'b0;
          if (tick_wrap) begin
            presc <= '0;
            if (last_tick) state <= S_IDLE;
            else           dur_cnt <= dur_cnt - 16'd1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BUZZER_SEQ_IRQ_EN
  logic irqen;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irqen     <= 1'b0;
      done      <= 1'b0;
      buzzerIrq <= 1'b0;
    end else begin
      if (wr_en && reg_addr == A_IRQEN) irqen <= PWDATA[0];
      if (fin && empty)                 done <= 1'b1;
      else if (wr_status && PWDATA[4])  done <= 1'b0;
      buzzerIrq <= irqen & done;
    end
  end
`else
  logic irqen;
  assign irqen = 1'b0;
  assign done  = 1'b0 & fin;
`endif

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (reg_addr)
        A_CTRL:   PRDATA[0] = en;
        A_STATUS: begin
          PRDATA[0]    = busy;
          PRDATA[1]    = empty;
          PRDATA[2]    = full;
          PRDATA[3]    = ovf;
          PRDATA[4]    = done;
          PRDATA[15:8] = 8'(count);
        end
        A_GAP:    PRDATA[15:0] = gap_r;
        A_IRQEN:  PRDATA[0] = irqen;
        default:  PRDATA = '0;
      endcase
    end
  end

endmodule
